// File: rtl/gamma_loader.sv
// Loads a 768-entry gamma curve (256 x R,G,B) from the curve ROM into the gamma
// corrector write port, gated to vertical blank, and drives the gamma enable.
module gamma_loader #(
  parameter int CURVE_BITS  = 3,
  parameter int ROM_LAT     = 1,
  parameter int WAIT_VBL    = 1,
  parameter int BYPASS_LOAD = 1
) (
  input  logic                   clk_sys,
  input  logic                   reset_n,
  input  logic                   gamma_present,
  input  logic                   vblank,
  input  logic                   en_cfg,
  input  logic                   load_req,
  input  logic [CURVE_BITS-1:0]  curve_sel,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [CURVE_BITS+9:0]  rom_addr,
  input  logic [7:0]             rom_data,
  output logic                   gamma_en,
  output logic                   gamma_wr,
  output logic [9:0]             gamma_wr_addr,
  output logic [7:0]             gamma_value
);

  typedef enum logic [2:0] {
    IDLE,
    WAITV,
    FETCH,
    WRITE,
    DONE
  } state_t;

  localparam logic [1:0] LAT_LAST   = 2'(ROM_LAT - 1);
  localparam logic [9:0] LAST_ENTRY = 10'd767;
  localparam logic       WAIT_EN    = (WAIT_VBL != 0);
  localparam logic       BYPASS     = (BYPASS_LOAD != 0);

  state_t                state;
  logic [CURVE_BITS-1:0] curve;
  logic [9:0]            cnt;
  logic [1:0]            wcnt;
  logic                  table_valid;
  logic                  vbl_m;
  logic                  vbl_s;
  logic                  vbl_s_d;
  logic                  vbl_rise;
  logic                  loading;

  assign vbl_rise = vbl_s & ~vbl_s_d;
  assign loading  = (state == FETCH) || (state == WRITE);

  // vblank comes from the video clock domain
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      vbl_m   <= 1'b0;
      vbl_s   <= 1'b0;
      vbl_s_d <= 1'b0;
    end else begin
      vbl_m   <= vblank;
      vbl_s   <= vbl_m;
      vbl_s_d <= vbl_s;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      curve         <= '0;
      cnt           <= '0;
      wcnt          <= '0;
      table_valid   <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      rom_addr      <= '0;
      gamma_en      <= 1'b0;
      gamma_wr      <= 1'b0;
      gamma_wr_addr <= '0;
      gamma_value   <= '0;
    end else begin
      done     <= 1'b0;
      err      <= 1'b0;
      gamma_wr <= 1'b0;
      gamma_en <= en_cfg & table_valid & gamma_present & ~(BYPASS & loading);

      case (state)
        IDLE: begin
          if (load_req) begin
            curve <= curve_sel;
            busy  <= 1'b1;
            cnt   <= '0;
            if (!gamma_present) begin
              state <= DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else if (WAIT_EN) begin
              state <= WAITV;
            end else begin
              state    <= FETCH;
              rom_addr <= {curve_sel, 10'd0};
              wcnt     <= '0;
            end
          end
        end

        WAITV: begin
          if (vbl_rise) begin
            state    <= FETCH;
            rom_addr <= {curve, cnt};
            wcnt     <= '0;
          end
        end

        // rom_addr is held stable for the whole ROM latency window
        FETCH: begin
          if (wcnt == LAT_LAST) begin
            state <= WRITE;
          end else begin
            wcnt <= wcnt + 2'd1;
          end
        end

        WRITE: begin
          gamma_wr      <= 1'b1;
          gamma_wr_addr <= cnt;
          gamma_value   <= rom_data;
          if (cnt == LAST_ENTRY) begin
            state       <= DONE;
            done        <= 1'b1;
            table_valid <= 1'b1;
          end else begin
            cnt      <= cnt + 10'd1;
            state    <= FETCH;
            rom_addr <= {curve, cnt + 10'd1};
            wcnt     <= '0;
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gamma_loader.sv
// Bench for gamma_loader: instance 0 (ROM_LAT=1, immediate start) and instance 1
// (ROM_LAT=3, vblank-gated), both checked against a curve-order write model.
module tb_gamma_loader;

  logic        clk;
  logic        reset_n;
  logic        gamma_present;
  logic        vblank;
  logic        en_cfg;
  logic [2:0]  curve_sel;
  logic        load_req      [2];
  logic        busy          [2];
  logic        done          [2];
  logic        err           [2];
  logic [12:0] rom_addr      [2];
  logic        gamma_en      [2];
  logic        gamma_wr      [2];
  logic [9:0]  gamma_wr_addr [2];
  logic [7:0]  gamma_value   [2];

  logic [7:0]  mem [8192];

  int vectors    = 0;
  int miscompares = 0;
  int exp_curve [2];
  int exp_idx   [2];
  int strobes   [2];
  logic prev_wr [2];
  bit tv_model;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [7:0] pipe [4];
    logic [7:0] rom_data;

    gamma_loader #(
      .CURVE_BITS (3),
      .ROM_LAT    (LAT),
      .WAIT_VBL   ((g == 0) ? 0 : 1),
      .BYPASS_LOAD(1)
    ) u_dut (
      .clk_sys      (clk),
      .reset_n      (reset_n),
      .gamma_present(gamma_present),
      .vblank       (vblank),
      .en_cfg       (en_cfg),
      .load_req     (load_req[g]),
      .curve_sel    (curve_sel),
      .busy         (busy[g]),
      .done         (done[g]),
      .err          (err[g]),
      .rom_addr     (rom_addr[g]),
      .rom_data     (rom_data),
      .gamma_en     (gamma_en[g]),
      .gamma_wr     (gamma_wr[g]),
      .gamma_wr_addr(gamma_wr_addr[g]),
      .gamma_value  (gamma_value[g])
    );

    // ROM with LAT cycles of read latency
    always @(posedge clk) begin
      pipe[0] <= mem[rom_addr[g]];
      for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
    end
    assign rom_data = pipe[LAT-1];
  end

  function automatic void chk(input string nm, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endfunction

  // Every strobe must carry the next entry of the selected curve, in order.
  initial begin
    prev_wr[0] = 1'b0;
    prev_wr[1] = 1'b0;
  end
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (gamma_wr[i]) begin
        chk("no_back_to_back_wr", int'(prev_wr[i]), 0);
        chk("wr_addr", int'(gamma_wr_addr[i]), exp_idx[i]);
        chk("wr_value", int'(gamma_value[i]), int'(mem[exp_curve[i]*1024 + exp_idx[i]]));
        chk("en_off_during_load", int'(gamma_en[i]), 0);
        exp_idx[i]++;
        strobes[i]++;
      end
      prev_wr[i] = gamma_wr[i];
    end
  end

  typedef struct {
    int curve;
    bit present;
    bit en;
    bit exp_err;
    int exp_strobes;
    int exp_cycles;
    bit poke;
  } vec_t;

  vec_t tbl [6];

  task automatic pulse_load(input int i, input int c);
    @(negedge clk);
    curve_sel    = 3'(c);
    exp_curve[i] = c;
    exp_idx[i]   = 0;
    strobes[i]   = 0;
    load_req[i]  = 1'b1;
    @(negedge clk);
    load_req[i]  = 1'b0;
  endtask

  task automatic run_row(input vec_t v);
    int k;
    gamma_present = v.present;
    en_cfg        = v.en;
    pulse_load(0, v.curve);
    k = 0;
    while (!done[0] && k < 4000) begin
      @(negedge clk);
      k++;
      load_req[0] = v.poke && (k == 50 || k == 401);
    end
    load_req[0] = 1'b0;
    if (!done[0]) begin
      chk("done_timeout", 0, 1);
      return;
    end
    #1;
    chk("accept_to_done_cycles", k, v.exp_cycles);
    chk("err_pulse", int'(err[0]), int'(v.exp_err));
    chk("busy_in_done", int'(busy[0]), 1);
    chk("strobe_count", strobes[0], v.exp_strobes);
    if (v.poke) load_req[0] = 1'b1;
    @(negedge clk);
    load_req[0] = 1'b0;
    if (!v.exp_err) tv_model = 1'b1;
    chk("done_one_cycle", int'(done[0]), 0);
    chk("busy_cleared", int'(busy[0]), 0);
    chk("gamma_en_after_done", int'(gamma_en[0]), int'(v.en & tv_model & v.present));
    repeat (3) @(negedge clk);
    #1;
    chk("req_in_done_ignored", int'(busy[0]), 0);
    chk("no_extra_strobes", strobes[0], v.exp_strobes);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vec_t rl;
    bit e;
    bit p;

    for (int a = 0; a < 8192; a++) mem[a] = 8'($urandom);
    tbl[0] = '{5, 1'b0, 1'b1, 1'b1, 0, 0, 1'b0};
    tbl[1] = '{2, 1'b1, 1'b1, 1'b0, 768, 1536, 1'b1};
    tbl[2] = '{7, 1'b1, 1'b0, 1'b0, 768, 1536, 1'b0};
    tbl[3] = '{int'($urandom_range(0, 7)), 1'b1, 1'b1, 1'b0, 768, 1536, 1'b1};
    tbl[4] = '{int'($urandom_range(0, 7)), 1'b0, 1'b1, 1'b1, 0, 0, 1'b1};
    tbl[5] = '{0, 1'b1, 1'b1, 1'b0, 768, 1536, 1'b0};

    reset_n       = 1'b0;
    gamma_present = 1'b1;
    vblank        = 1'b0;
    en_cfg        = 1'b1;
    curve_sel     = '0;
    load_req[0]   = 1'b0;
    load_req[1]   = 1'b0;
    tv_model      = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_curve[i] = 0;
      exp_idx[i]   = 0;
      strobes[i]   = 0;
    end
    #2;
    for (int i = 0; i < 2; i++) begin
      chk("rst_busy", int'(busy[i]), 0);
      chk("rst_done", int'(done[i]), 0);
      chk("rst_err", int'(err[i]), 0);
      chk("rst_gamma_wr", int'(gamma_wr[i]), 0);
      chk("rst_gamma_en", int'(gamma_en[i]), 0);
      chk("rst_rom_addr", int'(rom_addr[i]), 0);
      chk("rst_wr_addr", int'(gamma_wr_addr[i]), 0);
      chk("rst_value", int'(gamma_value[i]), 0);
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("en_without_table", int'(gamma_en[0]), 0);

    for (int r = 0; r < 6; r++) run_row(tbl[r]);

    // gamma_en follows en_cfg & present one cycle later once a table is loaded
    gamma_present = 1'b1;
    en_cfg        = 1'b1;
    @(negedge clk);
    en_cfg = 1'b0;
    #1;
    chk("en_latency_hold", int'(gamma_en[0]), 1);
    @(negedge clk);
    chk("en_latency_follow", int'(gamma_en[0]), 0);
    for (int t = 0; t < 24; t++) begin
      e = 1'($urandom);
      p = ($urandom_range(0, 3) != 0);
      en_cfg        = e;
      gamma_present = p;
      @(negedge clk);
      chk("gamma_en_random", int'(gamma_en[0]), int'(e & p & tv_model));
    end

    // vblank-gated load on instance 1: a vblank already high must not start it
    gamma_present = 1'b1;
    en_cfg        = 1'b1;
    vblank        = 1'b1;
    repeat (5) @(negedge clk);
    pulse_load(1, int'($urandom_range(0, 7)));
    repeat (20) @(negedge clk);
    chk("no_wr_while_vbl_high", strobes[1], 0);
    chk("busy_waiting_vbl", int'(busy[1]), 1);
    vblank = 1'b0;
    repeat (6) @(negedge clk);
    chk("no_wr_after_vbl_fall", strobes[1], 0);
    vblank = 1'b1;
    n = 0;
    while (!gamma_wr[1] && n < 50) begin
      @(posedge clk);
      n++;
      #1;
    end
    chk("vbl_to_first_wr", n, 7);
    while (!done[1] && n < 4000) begin
      @(posedge clk);
      n++;
      #1;
      if (n == 100) vblank = 1'b0;
    end
    chk("vbl_to_done_lat3", n, 3 + 768 * 4);
    @(negedge clk);
    #1;
    chk("lat3_strobe_count", strobes[1], 768);
    @(negedge clk);
    chk("lat3_busy_clear", int'(busy[1]), 0);
    chk("lat3_gamma_en", int'(gamma_en[1]), 1);

    // reset mid-load on instance 0 drops the table
    gamma_present = 1'b1;
    en_cfg        = 1'b1;
    pulse_load(0, int'($urandom_range(0, 7)));
    n = 0;
    while (!(strobes[0] >= 299 && gamma_wr[0]) && n < 2000) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("wr_before_reset", int'(gamma_wr[0]), 1);
    reset_n = 1'b0;
    #1;
    chk("async_rst_wr", int'(gamma_wr[0]), 0);
    chk("async_rst_busy", int'(busy[0]), 0);
    chk("async_rst_en", int'(gamma_en[0]), 0);
    tv_model = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("en_off_after_reset", int'(gamma_en[0]), 0);
    rl = '{int'($urandom_range(0, 7)), 1'b1, 1'b1, 1'b0, 768, 1536, 1'b0};
    run_row(rl);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
